// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the CPU
// load/store unit (port 0) and the debug/loader path (port 1).
// Arbitration is round-robin with a bounded burst lock. The granted
// request is steered onto the memory port, and read data is registered
// back to the port that issued the read.
module dmem_arbiter #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } own_t;

  own_t             r_own;
  own_t             w_ownNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic             r_last;
  logic             w_lastNext;
  logic             w_pick0;
  logic             w_pick1;
  logic             w_burstDone;
  logic             w_rd0;
  logic             w_rd1;

  assign w_burstDone = (r_cnt >= C_MAX);

  // Grant decision: the owner keeps the memory until its burst is used up
  // while the other port waits; from IDLE a tie goes to the port that did
  // not own the memory most recently.
  always_comb begin
    w_pick0 = 1'b0;
    w_pick1 = 1'b0;
    case (r_own)
      OWN0: begin
        if (req0 && !(req1 && w_burstDone)) w_pick0 = 1'b1;
        else if (req1)                      w_pick1 = 1'b1;
      end
      OWN1: begin
        if (req1 && !(req0 && w_burstDone)) w_pick1 = 1'b1;
        else if (req0)                      w_pick0 = 1'b1;
      end
      default: begin
        if (req0 && req1) begin
          w_pick0 = r_last;
          w_pick1 = !r_last;
        end else begin
          w_pick0 = req0;
          w_pick1 = req1;
        end
      end
    endcase
  end

  // Grants are suppressed during reset so the unreset memory is never touched.
  assign gnt0 = w_pick0 && !rst;
  assign gnt1 = w_pick1 && !rst;

  // Next owner, burst count and tie pointer derived from this cycle's grant.
  always_comb begin
    w_ownNext  = r_own;
    w_cntNext  = r_cnt;
    w_lastNext = r_last;
    if (w_pick0 || w_pick1) begin
      if ((w_pick0 && r_own == OWN0) || (w_pick1 && r_own == OWN1)) begin
        if (!w_burstDone) w_cntNext = r_cnt + 1'b1;
      end else begin
        w_ownNext  = w_pick1 ? OWN1 : OWN0;
        w_cntNext  = CNT_W'(1);
        w_lastNext = w_pick1;
      end
    end else begin
      w_ownNext = IDLE;
      w_cntNext = '0;
    end
  end

  // Arbitration state register; port 0 wins the first tie out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own  <= IDLE;
      r_cnt  <= '0;
      r_last <= 1'b1;
    end else begin
      r_own  <= w_ownNext;
      r_cnt  <= w_cntNext;
      r_last <= w_lastNext;
    end
  end

  assign mem_addr    = gnt1 ? addr1 : addr0;
  assign mem_wr_data = gnt1 ? wdata1 : wdata0;
  assign mem_wr_en   = (gnt0 && we0) || (gnt1 && we1);
  assign mem_rd_en   = (gnt0 && !we0) || (gnt1 && !we1);

  assign w_rd0 = gnt0 && !we0;
  assign w_rd1 = gnt1 && !we1;

  // Read return: capture memory data for the port whose read was granted
  // and flag it valid for exactly the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= w_rd0;
      rvalid1 <= w_rd1;
      if (w_rd0) rdata0 <= mem_rd_data;
      if (w_rd1) rdata1 <= mem_rd_data;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives dmem_arbiter against a behavioural data memory,
// predicts grants with an arbitration model and checks read data through
// per-port scoreboard queues.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic [ADDR_W-1:0] memAddr;
  logic              memWrEn, memRdEn;
  logic [DATA_W-1:0] memWrData, memRdData;

  logic [DATA_W-1:0] tbMem  [32];
  logic [DATA_W-1:0] refMem [32];

  int checkCount = 0;
  int failCount  = 0;

  int mOwn, mCnt, mLast;
  bit expRv0, expRv1, expG0, expG1;
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int waitCnt0, waitCnt1;
  logic obsG0, obsG1, obsRv0;
  logic [DATA_W-1:0] obsRd0;

  dmem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(memAddr), .mem_wr_en(memWrEn), .mem_wr_data(memWrData),
    .mem_rd_en(memRdEn), .mem_rd_data(memRdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge, no reset.
  assign memRdData = tbMem[memAddr];
  initial begin
    for (int i = 0; i < 32; i++) begin
      tbMem[i]  = (i * 32'h01010101) ^ 32'h5A5A_0000;
      refMem[i] = (i * 32'h01010101) ^ 32'h5A5A_0000;
    end
    forever begin
      @(posedge clk);
      if (memWrEn) tbMem[memAddr] <= memWrData;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic resetModel();
    mOwn = 0; mCnt = 0; mLast = 1;
    expRv0 = 0; expRv1 = 0; expG0 = 0; expG1 = 0;
    q0.delete(); q1.delete();
    waitCnt0 = 0; waitCnt1 = 0;
  endtask

  // Arbitration reference: the current owner (if any) is preferred unless
  // its burst is spent and the other side is waiting.
  task automatic predictGrant(input bit r0, input bit r1, output bit e0, output bit e1);
    bit want[2];
    int owner, other, winner;
    want[0] = r0; want[1] = r1;
    winner = -1;
    if (mOwn != 0) begin
      owner = mOwn - 1;
      other = 1 - owner;
      if (want[owner] && !(want[other] && mCnt >= MAX_BURST)) winner = owner;
      else if (want[other]) winner = other;
    end else if (r0 && r1) begin
      winner = (mLast == 0) ? 1 : 0;
    end else if (r0) begin
      winner = 0;
    end else if (r1) begin
      winner = 1;
    end
    e0 = (winner == 0);
    e1 = (winner == 1);
  endtask

  task automatic stepCycle();
    bit e0, e1;
    int gp;
    @(negedge clk);
    obsRv0 = rvalid0;
    obsRd0 = rdata0;
    checkOutput("rvalid0", rvalid0, expRv0);
    checkOutput("rvalid1", rvalid1, expRv1);
    if (expRv0 && q0.size() > 0) checkOutput("rdata0", rdata0, q0.pop_front());
    if (expRv1 && q1.size() > 0) checkOutput("rdata1", rdata1, q1.pop_front());
    predictGrant(req0, req1, e0, e1);
    obsG0 = gnt0;
    obsG1 = gnt1;
    checkOutput("gnt0", gnt0, e0);
    checkOutput("gnt1", gnt1, e1);
    checkOutput("oneGrant", gnt0 & gnt1, 0);
    checkOutput("memWrEn", memWrEn, (e0 && we0) || (e1 && we1));
    checkOutput("memRdEn", memRdEn, (e0 && !we0) || (e1 && !we1));
    if (e0 || e1) checkOutput("memAddr", memAddr, e1 ? addr1 : addr0);
    if ((e0 && we0) || (e1 && we1)) checkOutput("memWrData", memWrData, e1 ? wdata1 : wdata0);
    waitCnt0 = (req0 && !gnt0) ? waitCnt0 + 1 : 0;
    waitCnt1 = (req1 && !gnt1) ? waitCnt1 + 1 : 0;
    checkOutput("starve0", waitCnt0 > MAX_BURST, 0);
    checkOutput("starve1", waitCnt1 > MAX_BURST, 0);
    expRv0 = e0 && !we0;
    expRv1 = e1 && !we1;
    if (e0) begin
      if (we0) refMem[addr0] = wdata0;
      else     q0.push_back(refMem[addr0]);
    end
    if (e1) begin
      if (we1) refMem[addr1] = wdata1;
      else     q1.push_back(refMem[addr1]);
    end
    if (e0 || e1) begin
      gp = e1 ? 1 : 0;
      if (mOwn == gp + 1) begin
        if (mCnt < MAX_BURST) mCnt++;
      end else begin
        mOwn = gp + 1; mCnt = 1; mLast = gp;
      end
    end else begin
      mOwn = 0; mCnt = 0;
    end
    expG0 = e0;
    expG1 = e1;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                               input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    stepCycle();
  endtask

  bit burstExp1 [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
  bit dropExp1  [7] = '{0, 0, 1, 1, 1, 1, 0};

  logic              curReq0, curReq1, curWe0, curWe1;
  logic [ADDR_W-1:0] curAddr0, curAddr1;
  logic [DATA_W-1:0] curData0, curData1;

  initial begin
    resetModel();
    rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 5'd1; addr1 = 5'd2; wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;

    // Reset with both ports requesting writes: nothing may reach the memory.
    @(negedge clk);
    checkOutput("rstGnt0", gnt0, 0);
    checkOutput("rstGnt1", gnt1, 0);
    checkOutput("rstWrEn", memWrEn, 0);
    checkOutput("rstRdEn", memRdEn, 0);
    checkOutput("rstRvalid0", rvalid0, 0);
    checkOutput("rstRvalid1", rvalid1, 0);
    checkOutput("rstRdata0", rdata0, 0);
    checkOutput("rstRdata1", rdata1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First tie after reset goes to port 0.
    applyStimulus(1, 0, 5'd3, 0, 1, 0, 5'd4, 0);
    checkOutput("firstTie0", obsG0, 1);
    checkOutput("firstTie1", obsG1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Port 0 write then read-back of the same address on the next cycle.
    applyStimulus(1, 1, 5'd11, 32'hDEADBEEF, 0, 0, 0, 0);
    checkOutput("rtWrGnt", obsG0, 1);
    applyStimulus(1, 0, 5'd11, 0, 0, 0, 0, 0);
    checkOutput("rtRdGnt", obsG0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rtRvalid", obsRv0, 1);
    checkOutput("rtRdata", obsRd0, 32'hDEADBEEF);

    // Burst bound: port 0 from cycle 0, port 1 joins at cycle 2.
    for (int c = 0; c < 9; c++) begin
      applyStimulus(1, 0, 5'(c), 0, (c >= 2), 0, 5'(c + 16), 0);
      checkOutput($sformatf("burst%0d_g1", c), obsG1, burstExp1[c]);
      checkOutput($sformatf("burst%0d_g0", c), obsG0, !burstExp1[c]);
    end

    // Ties from idle alternate with the most recent owner.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 5'd5, 0, 1, 0, 5'd6, 0);
    checkOutput("idleTieA", obsG1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 5'd7, 0, 1, 0, 5'd8, 0);
    checkOutput("idleTieB", obsG0, 1);

    // Owner drops its request: the other port takes over with a fresh burst.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 7; c++) begin
      applyStimulus((c != 2), 0, 5'(c + 8), 0, (c >= 2), 1, 5'(c + 20), 32'hC0DE_0000 + c);
      checkOutput($sformatf("drop%0d_g1", c), obsG1, dropExp1[c]);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset arriving mid-cycle cancels a granted read; async reset clears rvalid.
    req0 = 1; we0 = 0; addr0 = 5'd11; req1 = 0; we1 = 0;
    #3;
    checkOutput("preRstGnt", gnt0, 1);
    rst = 1'b1;
    #1;
    checkOutput("midRstGnt", gnt0, 0);
    checkOutput("midRstRdEn", memRdEn, 0);
    @(posedge clk);
    #1;
    checkOutput("rstNoData", rvalid0, 0);
    rst = 1'b0;
    resetModel();
    stepCycle();
    checkOutput("rvBeforeRst", rvalid0, 1);
    rst = 1'b1;
    #1;
    checkOutput("rvAsyncClr", rvalid0, 0);
    checkOutput("rdataAsyncClr", rdata0, 0);
    req0 = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    resetModel();

    // Random traffic; each request is held stable until the model grants it.
    curReq0 = 0; curReq1 = 0; curWe0 = 0; curWe1 = 0;
    curAddr0 = 0; curAddr1 = 0; curData0 = 0; curData1 = 0;
    for (int n = 0; n < 2000; n++) begin
      if (!curReq0 || expG0) begin
        curReq0  = ($urandom_range(0, 3) != 0);
        curWe0   = 1'($urandom_range(0, 1));
        curAddr0 = 5'($urandom_range(0, 31));
        curData0 = $urandom;
      end
      if (!curReq1 || expG1) begin
        curReq1  = ($urandom_range(0, 3) != 0);
        curWe1   = 1'($urandom_range(0, 1));
        curAddr1 = 5'($urandom_range(0, 31));
        curData1 = $urandom;
      end
      applyStimulus(curReq0, curWe0, curAddr0, curData0, curReq1, curWe1, curAddr1, curData1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported `Data_Memory` (combinational read, write on `posedge clk`) between two requesters:

- Port 0 is the CPU load/store unit.
- Port 1 is the debug/loader path.

It grants one access per cycle using round-robin with a bounded burst lock. It steers the granted request onto the memory port and returns registered read data to the requester that issued the read. It sits between the core's MEM stage and the data memory.

## Interface
- `ADDR_W`, default 5: memory address width; matches the `Data_Memory` `addr`.
- `DATA_W`, default 32: data width.
- `MAX_BURST`, default 4: maximum consecutive grants to one port while the other port is requesting (≥1).

Ports, clock and reset first:
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req0`, `req1`  in  1: access request; must be held with its fields stable until granted.
- `we0`, `we1`  in  1: 1 = write, 0 = read.
- `addr0`, `addr1`  in  `ADDR_W`: word address.
- `wdata0`, `wdata1`  in  `DATA_W`: write data.
- `gnt0`, `gnt1`  out  1: combinational grant; the access completes at the closing edge of the cycle.
- `rvalid0`, `rvalid1`  out  1: registered; high for one cycle following a granted read.
- `rdata0`, `rdata1`  out  `DATA_W`: registered read data; holds its value until that port's next read.
- `mem_addr`  out  `ADDR_W`, `mem_wr_en` out 1, `mem_wr_data` out `DATA_W`, `mem_rd_en` out 1: memory-side port.
- `mem_rd_data`  in  `DATA_W`: combinational read data from memory.

## Operation
- State register `own` ∈ {IDLE, OWN0, OWN1}.
  - Burst counter `cnt`: range 0..`MAX_BURST`, saturating.
  - Tie pointer `last`: 1 bit, the most recent owner.
- Grant decision, evaluated every cycle:
  - **`own`=OWNi:**
    - Grant port i if `req_i` && !(`req_j` && `cnt` ≥ `MAX_BURST`).
    - Otherwise grant port j if `req_j`.
    - Otherwise grant nothing.
  - **`own`=IDLE:**
    - Single requester: grant it.
    - Both requesting: grant the port ≠ `last`.
- Next-state update:
  - Grant to the same port as `own`: `cnt` ← min(`cnt`+1, `MAX_BURST`).
  - Grant to a different port, or from IDLE: `own` ← that port, `cnt` ← 1, `last` ← that port.
  - No grant: `own` ← IDLE, `cnt` ← 0, `last` unchanged.
- Memory steering:
  - `mem_addr`/`mem_wr_data` come from the granted port.
  - With no grant they come from port 0's fields, with both enables 0.
  - `mem_wr_en` = grant && `we`.
  - `mem_rd_en` = grant && !`we`.
- Read return:
  - On a granted read by port i, capture `mem_rd_data` into `rdata_i` at the edge.
  - `rvalid_i` = 1 for the next cycle.
- Writes produce no response beyond `gnt`.
- Gating and invariants:
  - While `rst`=1, `gnt0`/`gnt1`/`mem_wr_en`/`mem_rd_en` are forced 0; the memory has no reset and must not be written.
  - At most one of `gnt0`/`gnt1` is high in any cycle.

## Timing
- Reset values:
  - `own`=IDLE, `cnt`=0, `last`=1, so port 0 wins the first tie.
  - `rvalid0`/`rvalid1`=0, `rdata0`/`rdata1`=0, all grants and enables 0.
- Latency:
  - Grant can be asserted in the same cycle `req` rises.
  - A write takes effect at that cycle's closing edge.
  - Read data is valid one cycle after the grant.
- Throughput: one access per cycle; back-to-back grants to the same port are allowed.
- Starvation bound: a continuously requesting port waits at most `MAX_BURST` cycles.
- Reset mid-operation:
  - Async assertion clears `rvalid` immediately.
  - A read granted in the cycle reset asserts returns no data.
- Read-after-write, same address, consecutive cycles: the read returns the newly written value.

## Test plan
- **Reset.** Assert `rst` with `req0`=`req1`=1 → `gnt0`=`gnt1`=0, `mem_wr_en`=0, `rvalid0`=`rvalid1`=0. Release `rst` → first cycle grants port 0.
- **Single-port round trip.** Port 0 writes 0xDEADBEEF at address 11. Next cycle, port 0 reads address 11 → `gnt0`=1 in both cycles; `rvalid0`=1 one cycle after the read grant; `rdata0`=0xDEADBEEF.
- **Burst bound.** `MAX_BURST`=4; `req0` held continuously from cycle 0; `req1` raised at cycle 2 → port 0 granted cycles 0–3, port 1 granted at cycle 4. With both still requesting, port 1 keeps the grant for 4 cycles, then it returns to port 0.
- **Simultaneous from idle.** Both ports request from IDLE with `last`=0 → port 1 granted. Repeat after an idle cycle → port 0 granted.
- **Owner drops request.** Owner drops `req` while the other port requests → the other port is granted in that same cycle and `cnt` restarts at 1.
- **Random traffic vs. scoreboard.** Random reads/writes on both ports over 2000 cycles, checked against a reference memory model → no mismatches, no double grants, no port waits more than 4 cycles.
